// File: rtl/addr_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_delay_pkg
// Description : Shared defaults and tap-select clamp for addr_delay_line.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_delay_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH = 11;
    localparam int c_DEFAULT_NUM_CH     = 2;
    localparam int c_DEFAULT_DEPTH      = 4;

    // Map a raw delay request onto the legal tap range 1..depth.
    function automatic int clamp_sel(input int sel, input int depth);
        if (sel == 0)
            return 1;
        else if (sel > depth)
            return depth;
        else
            return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : addr_delay_stage
// Description : One delay-line register stage; priority reset > flush > hold > shift.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_delay_stage #(
    parameter int WIDTH = 1
) (
    input  logic             pll_clock,
    input  logic             reset_n,
    input  logic             hold,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* preserve *) logic [WIDTH-1:0] r_q;

    always_ff @(posedge pll_clock) begin
        if (!reset_n)
            r_q <= '0;
        else if (flush)
            r_q <= '0;
        else if (!hold)
            r_q <= d;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/addr_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : addr_delay_line
// Description : Multi-channel address/enable delay line with runtime tap,
//               hold and flush. Optional ADDR_DELAY_OCCUPANCY_EN adds the
//               registered 'inflight' occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_delay_line
    import addr_delay_pkg::*;
#(
    parameter  int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter  int NUM_CH     = c_DEFAULT_NUM_CH,
    parameter  int DEPTH      = c_DEFAULT_DEPTH,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                         pll_clock,
    input  logic                         reset_n,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_CH-1:0]            e_in,
    input  logic                         hold,
    input  logic                         flush,
    input  logic [SEL_W-1:0]             delay_sel,
    output logic [NUM_CH*ADDR_WIDTH-1:0] addr_out,
    output logic [NUM_CH-1:0]            e_out
`ifdef ADDR_DELAY_OCCUPANCY_EN
    ,
    output logic [SEL_W-1:0]             inflight
`endif
);

    localparam int c_STAGE_W = NUM_CH * (ADDR_WIDTH + 1);

    // Each stage word is {addresses, enables}; enables sit in the low bits.
    logic [c_STAGE_W-1:0]            w_in;
    logic [DEPTH-1:0][c_STAGE_W-1:0] w_stage_q;
    logic [c_STAGE_W-1:0]            w_tap;
    int                              w_eff_sel;

    assign w_in      = {addr_in, e_in};
    assign w_eff_sel = clamp_sel(int'(delay_sel), DEPTH);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            addr_delay_stage #(.WIDTH(c_STAGE_W)) u_stage (
                .pll_clock (pll_clock),
                .reset_n   (reset_n),
                .hold      (hold),
                .flush     (flush),
                .d         (w_in),
                .q         (w_stage_q[k])
            );
        end else begin : g_rest
            addr_delay_stage #(.WIDTH(c_STAGE_W)) u_stage (
                .pll_clock (pll_clock),
                .reset_n   (reset_n),
                .hold      (hold),
                .flush     (flush),
                .d         (w_stage_q[k-1]),
                .q         (w_stage_q[k])
            );
        end
    end

    // Tap mux over flop outputs only, so no input reaches the outputs combinationally.
    always_comb begin
        w_tap = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k + 1 == w_eff_sel)
                w_tap = w_stage_q[k];
        end
    end

    assign addr_out = w_tap[c_STAGE_W-1:NUM_CH];
    assign e_out    = w_tap[NUM_CH-1:0];

`ifdef ADDR_DELAY_OCCUPANCY_EN
    logic [SEL_W-1:0] r_inflight;
    int               w_occ_next;

    // Count over the post-shift contents: stage 1 takes e_in, stage k+1 takes stage k.
    always_comb begin
        w_occ_next = 0;
        if (|e_in)
            w_occ_next = 1;
        for (int k = 1; k < DEPTH; k++) begin
            if ((k + 1 <= w_eff_sel) && (|w_stage_q[k-1][NUM_CH-1:0]))
                w_occ_next = w_occ_next + 1;
        end
    end

    always_ff @(posedge pll_clock) begin
        if (!reset_n)
            r_inflight <= '0;
        else if (flush)
            r_inflight <= '0;
        else if (!hold)
            r_inflight <= SEL_W'(w_occ_next);
    end

    assign inflight = r_inflight;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addr_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_delay_line
// Description : Scoreboard bench for addr_delay_line (2 channels, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_delay_line;

    localparam int AW  = 11;
    localparam int NCH = 2;
    localparam int DEP = 4;
    localparam int SW  = $clog2(DEP + 1);

    typedef struct {
        logic [NCH*AW-1:0] addr;
        logic [NCH-1:0]    e;
        logic [SW-1:0]     infl;
    } exp_t;

    logic              pll_clock = 1'b0;
    logic              reset_n;
    logic [NCH*AW-1:0] addr_in;
    logic [NCH-1:0]    e_in;
    logic              hold;
    logic              flush;
    logic [SW-1:0]     delay_sel;
    logic [NCH*AW-1:0] addr_out;
    logic [NCH-1:0]    e_out;
`ifdef ADDR_DELAY_OCCUPANCY_EN
    logic [SW-1:0]     inflight;
`endif

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    addr_delay_line #(.ADDR_WIDTH(AW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .addr_in   (addr_in),
        .e_in      (e_in),
        .hold      (hold),
        .flush     (flush),
        .delay_sel (delay_sel),
        .addr_out  (addr_out),
        .e_out     (e_out)
`ifdef ADDR_DELAY_OCCUPANCY_EN
        ,
        .inflight  (inflight)
`endif
    );

    always #5 pll_clock = ~pll_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                                     input logic [NCH-1:0] e, input int infl);
        exp_t x;
        x.addr = {a1, a0};
        x.e    = e;
        x.infl = SW'(infl);
        sb.push_back(x);
    endfunction

    // Present one beat of control/data, take one rising edge, settle for sampling.
    task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                         input logic [NCH-1:0] e, input logic h, input logic f,
                         input logic rn);
        addr_in = {a1, a0};
        e_in    = e;
        hold    = h;
        flush   = f;
        reset_n = rn;
        @(posedge pll_clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        delay_sel = 3'd3;
        for (int i = 0; i < 2; i++) push_exp(0, 0, 2'b00, 0);
        for (int i = 0; i < 2; i++) begin
            drive(11'h555, 11'h2AA, 2'b11, 1'b1, 1'b1, 1'b0);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL reset addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL reset e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL reset inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    task automatic test_delay3();
        exp_t x;
        int infl[6] = '{1, 1, 1, 0, 0, 0};
        delay_sel = 3'd3;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) push_exp(11'h7FF, 11'h123, 2'b01, infl[i]);
            else        push_exp(0, 0, 2'b00, infl[i]);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(11'h7FF, 11'h123, 2'b01, 1'b0, 1'b0, 1'b1);
            else        drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL delay3 addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL delay3 e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL delay3 inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int infl[7] = '{1, 1, 1, 0, 0, 0, 0};
        delay_sel = 3'd1;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) push_exp(AW'(11'h400 + i), AW'(i + 1), 2'b11, infl[i]);
            else       push_exp(0, 0, 2'b00, infl[i]);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(AW'(11'h400 + i), AW'(i + 1), 2'b11, 1'b0, 1'b0, 1'b1);
            else       drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL b2b addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL b2b e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL b2b inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    task automatic test_hold();
        exp_t x;
        int infl[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        delay_sel = 3'd4;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) push_exp(11'h155, 11'h2AA, 2'b11, infl[i]);
            else        push_exp(0, 0, 2'b00, infl[i]);
        end
        for (int i = 0; i < 9; i++) begin
            if (i == 0)                drive(11'h155, 11'h2AA, 2'b11, 1'b0, 1'b0, 1'b1);
            else if (i == 2 || i == 3) drive(11'h3FF, 11'h3FF, 2'b11, 1'b1, 1'b0, 1'b1);
            else                       drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL hold addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL hold e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL hold inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    task automatic test_flush();
        exp_t x;
        int infl[8] = '{1, 2, 3, 0, 0, 0, 0, 0};
        delay_sel = 3'd4;
        for (int i = 0; i < 8; i++) push_exp(0, 0, 2'b00, infl[i]);
        for (int i = 0; i < 8; i++) begin
            if (i < 3)       drive(AW'(11'h20 + i), AW'(11'h10 + i), 2'b01, 1'b0, 1'b0, 1'b1);
            else if (i == 3) drive(11'h055, 11'h055, 2'b11, 1'b1, 1'b1, 1'b1);
            else             drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL flush addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL flush e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL flush inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    task automatic test_clamp();
        exp_t x;
        logic [SW-1:0] sel_list[2] = '{3'd0, 3'd7};
        int            lat[2]      = '{1, 4};
        for (int s = 0; s < 2; s++) begin
            delay_sel = sel_list[s];
            for (int i = 0; i < 6; i++) begin
                if (i == lat[s] - 1) push_exp(11'h0F0, 11'h00F, 2'b10, (i < lat[s]) ? 1 : 0);
                else                 push_exp(0, 0, 2'b00, (i < lat[s]) ? 1 : 0);
            end
            for (int i = 0; i < 6; i++) begin
                if (i == 0) drive(11'h0F0, 11'h00F, 2'b10, 1'b0, 1'b0, 1'b1);
                else        drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
                x = sb.pop_front();
                n_cmp++;
                if (addr_out !== x.addr) begin
                    n_fail++;
                    $display("FAIL clamp sel=%0d addr edge %0d: got %h want %h", delay_sel, i, addr_out, x.addr);
                end
                n_cmp++;
                if (e_out !== x.e) begin
                    n_fail++;
                    $display("FAIL clamp sel=%0d e edge %0d: got %b want %b", delay_sel, i, e_out, x.e);
                end
`ifdef ADDR_DELAY_OCCUPANCY_EN
                n_cmp++;
                if (inflight !== x.infl) begin
                    n_fail++;
                    $display("FAIL clamp sel=%0d inflight edge %0d: got %0d want %0d", delay_sel, i, inflight, x.infl);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t x;
        int infl[7] = '{1, 2, 0, 0, 0, 0, 0};
        delay_sel = 3'd2;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) push_exp(11'h301, 11'h101, 2'b11, infl[i]);
            else        push_exp(0, 0, 2'b00, infl[i]);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 2)       drive(AW'(11'h301 + i), AW'(11'h101 + i), 2'b11, 1'b0, 1'b0, 1'b1);
            else if (i == 2) drive(11'h333, 11'h333, 2'b11, 1'b1, 1'b0, 1'b0);
            else             drive(0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
            x = sb.pop_front();
            n_cmp++;
            if (addr_out !== x.addr) begin
                n_fail++;
                $display("FAIL rst_mid addr edge %0d: got %h want %h", i, addr_out, x.addr);
            end
            n_cmp++;
            if (e_out !== x.e) begin
                n_fail++;
                $display("FAIL rst_mid e edge %0d: got %b want %b", i, e_out, x.e);
            end
`ifdef ADDR_DELAY_OCCUPANCY_EN
            n_cmp++;
            if (inflight !== x.infl) begin
                n_fail++;
                $display("FAIL rst_mid inflight edge %0d: got %0d want %0d", i, inflight, x.infl);
            end
`endif
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        addr_in   = '0;
        e_in      = '0;
        hold      = 1'b0;
        flush     = 1'b0;
        delay_sel = 3'd3;
        test_reset();
        test_delay3();
        test_back_to_back();
        test_hold();
        test_flush();
        test_clamp();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
